// File: rtl/v_dresizer_repack_if.sv
// AXI4-Stream video bus carrying one pixel per beat.
//  tdata  : pixel
//  tvalid : beat valid
//  tready : sink ready
//  tuser  : start of frame
//  tlast  : end of line
interface v_dresizer_repack_if #(
    parameter int unsigned PIXEL_WIDTH = 24
);
    logic [PIXEL_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tuser;
    logic                   tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/v_dresizer_repack.sv
// Repacks the bubbly, decimated output of the 1-ppc down-resizer into a gap-tolerant
// AXI4-Stream video. Accepted pixels are buffered in a FIFO; tuser/tlast are regenerated
// from the programmed output geometry, frame sync follows input SOF, framing errors pulse.
// Ports:
//  aclk, aresetn   clock / asynchronous active-low reset
//  s_axis          slave stream from the down-resizer (tlast ignored)
//  m_axis          master stream with regenerated tuser (SOF) and tlast (EOL)
//  frame_cnt       completed output frames, wrapping
//  err_early_sof   1-cycle pulse: SOF emitted before the previous frame completed
//  err_miss_sof    1-cycle pulse: frame start emitted without SOF
module v_dresizer_repack #(
    parameter int unsigned PIXEL_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned OUT_W       = 960,
    parameter int unsigned OUT_H       = 540,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    v_dresizer_repack_if.slave       s_axis,
    v_dresizer_repack_if.master      m_axis,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic                     err_early_sof,
    output logic                     err_miss_sof
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef logic [AW:0]      ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic                   sof;
        logic [PIXEL_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic {
        SYNC,
        RUN
    } in_state_e;

    in_state_e state_q, state_d;

    entry_t mem [FIFO_DEPTH];
    ptr_t   wr_ptr_q;
    ptr_t   wr_pub_q;
    ptr_t   rd_ptr_q;

    logic   s_ready_q;
    logic   m_valid_q;
    logic   m_user_q;
    logic   m_last_q;
    logic [PIXEL_WIDTH-1:0] m_data_q;

    cnt_t   col_q;
    cnt_t   line_q;
    logic   started_q;

    logic   accept_c;
    logic   wr_en_c;
    logic   empty_c;
    logic   load_c;
    ptr_t   count_c;
    ptr_t   count_next_c;
    entry_t head_c;

    cnt_t   cur_col_c;
    cnt_t   cur_line_c;
    cnt_t   col_next_c;
    cnt_t   line_next_c;
    logic   eol_c;
    logic   eof_c;
    logic   early_c;
    logic   miss_c;

    // Input tlast is unreliable after decimation and intentionally unused.
    logic   unused_tlast;
    assign unused_tlast = s_axis.tlast;

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tuser  = m_user_q;
    assign m_axis.tlast  = m_last_q;

    // SYNC discards everything up to the first SOF beat; RUN keeps all beats.
    assign accept_c = s_axis.tvalid & s_ready_q;
    assign wr_en_c  = accept_c & ((state_q == RUN) | s_axis.tuser);

    // Write pointer is published to the read side one cycle late: this gives the
    // two-edge input-to-output latency while fullness still counts every stored beat.
    assign count_c      = wr_ptr_q - rd_ptr_q;
    assign empty_c      = (rd_ptr_q == wr_pub_q);
    assign head_c       = mem[rd_ptr_q[AW-1:0]];
    assign load_c       = (~m_valid_q | m_axis.tready) & ~empty_c;
    assign count_next_c = count_c + ptr_t'(wr_en_c) - ptr_t'(load_c);

    // Input state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Input next-state: leave SYNC on the first accepted SOF beat, then stay in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (accept_c && s_axis.tuser) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SYNC;
        endcase
    end

    // FIFO storage, no reset needed.
    always_ff @(posedge aclk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q[AW-1:0]] <= '{sof: s_axis.tuser, data: s_axis.tdata};
        end
    end

    // FIFO pointers and registered input ready (low once the FIFO will be full).
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            wr_pub_q  <= '0;
            rd_ptr_q  <= '0;
            s_ready_q <= 1'b0;
        end else begin
            if (wr_en_c) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (load_c)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            wr_pub_q  <= wr_ptr_q;
            s_ready_q <= (count_next_c != ptr_t'(FIFO_DEPTH));
        end
    end

    // Position of the beat being loaded and framing error detection.
    always_comb begin
        cur_col_c  = col_q;
        cur_line_c = line_q;
        early_c    = 1'b0;
        miss_c     = 1'b0;
        if (head_c.sof) begin
            cur_col_c  = '0;
            cur_line_c = '0;
            early_c    = (col_q != '0) || (line_q != '0);
        end else begin
            miss_c     = started_q && (col_q == '0) && (line_q == '0);
        end
        eol_c       = (cur_col_c == cnt_t'(OUT_W - 1));
        eof_c       = eol_c && (cur_line_c == cnt_t'(OUT_H - 1));
        col_next_c  = eol_c ? '0 : cur_col_c + cnt_t'(1);
        line_next_c = eof_c ? '0 : (eol_c ? cur_line_c + cnt_t'(1) : cur_line_c);
    end

    // Output register slice and geometry counters; both advance on the load.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_user_q      <= 1'b0;
            m_last_q      <= 1'b0;
            col_q         <= '0;
            line_q        <= '0;
            started_q     <= 1'b0;
            frame_cnt     <= '0;
            err_early_sof <= 1'b0;
            err_miss_sof  <= 1'b0;
        end else begin
            err_early_sof <= 1'b0;
            err_miss_sof  <= 1'b0;
            if (load_c) begin
                m_valid_q     <= 1'b1;
                m_data_q      <= head_c.data;
                m_user_q      <= head_c.sof;
                m_last_q      <= eol_c;
                col_q         <= col_next_c;
                line_q        <= line_next_c;
                started_q     <= 1'b1;
                err_early_sof <= early_c;
                err_miss_sof  <= miss_c;
                if (eof_c) frame_cnt <= frame_cnt + cnt_t'(1);
            end else if (m_axis.tready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_v_dresizer_repack.sv
// Scoreboard bench for v_dresizer_repack with a 4x2 output geometry.
module tb_v_dresizer_repack;

    localparam int unsigned PW = 24;
    localparam int unsigned CW = 16;

    logic aclk;
    logic rst_n;
    logic [CW-1:0] frame_cnt;
    logic err_early_sof;
    logic err_miss_sof;

    v_dresizer_repack_if #(.PIXEL_WIDTH(PW)) s_if ();
    v_dresizer_repack_if #(.PIXEL_WIDTH(PW)) m_if ();

    v_dresizer_repack #(
        .PIXEL_WIDTH (PW),
        .FIFO_DEPTH  (16),
        .OUT_W       (4),
        .OUT_H       (2),
        .CNT_W       (CW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (rst_n),
        .s_axis        (s_if.slave),
        .m_axis        (m_if.master),
        .frame_cnt     (frame_cnt),
        .err_early_sof (err_early_sof),
        .err_miss_sof  (err_miss_sof)
    );

    typedef struct packed {
        logic [PW-1:0] d;
        logic          u;
        logic          l;
    } exp_t;

    exp_t sb_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_early  = 0;
    int   n_miss   = 0;
    int   first_valid_cyc = -1;
    int   first_accept_cyc = -1;
    bit   seen_valid = 0;
    bit   stalled = 0;
    exp_t hold;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: error pulse counting, stall stability, scoreboard pops on handshake.
    always @(negedge aclk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (err_early_sof) n_early++;
            if (err_miss_sof)  n_miss++;
            if (m_if.tvalid && !seen_valid) begin
                seen_valid = 1;
                first_valid_cyc = cyc;
            end
            if (stalled)
                check("stall_hold", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast},
                      {1'b1, hold.d, hold.u, hold.l});
            if (m_if.tvalid && m_if.tready) begin
                stalled = 0;
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", {m_if.tdata, m_if.tuser, m_if.tlast}, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_beat", {m_if.tdata, m_if.tuser, m_if.tlast}, {e.d, e.u, e.l});
                end
            end else if (m_if.tvalid) begin
                stalled = 1;
                hold = '{d: m_if.tdata, u: m_if.tuser, l: m_if.tlast};
            end else begin
                stalled = 0;
            end
        end
    end

    // Drive one beat until accepted; input tlast is driven inverted since it must be ignored.
    task automatic beat(input logic [PW-1:0] d, input logic u, input logic l, input bit keep);
        int n;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = ~l;
        s_if.tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge aclk);
            if (s_if.tready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'(n), 64'd0);
                break;
            end
        end
        if (first_accept_cyc < 0) first_accept_cyc = cyc + 1;
        if (keep) sb_q.push_back('{d: d, u: u, l: l});
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        idle(3);
    endtask

    task automatic do_reset();
        @(posedge aclk);
        #1;
        rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        check("rst_s_tready", 64'(s_if.tready), 64'd0);
        check("rst_outputs", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata, err_early_sof, err_miss_sof},
              64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    // Standard 8-beat frame: SOF on beat 0, EOL on beats 3 and 7, optional gap cycles.
    task automatic frame8(input logic [PW-1:0] base, input int gap);
        for (int i = 0; i < 8; i++) begin
            beat(base + PW'(i), (i == 0), (i % 4 == 3), 1'b1);
            if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        int acc;
        int k;
        rst_n = 1'b0;
        s_if.tdata = '0;
        s_if.tvalid = 1'b0;
        s_if.tuser = 1'b0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b1;

        // 1: basic frame, latency and frame count.
        do_reset();
        frame8(24'h000000, 0);
        drain();
        check("t1_latency", 64'(first_valid_cyc - first_accept_cyc), 64'd2);
        check("t1_frame_cnt", 64'(frame_cnt), 64'd1);

        // 2: input bubbles.
        frame8(24'h000010, 1);
        drain();
        check("t2_frame_cnt", 64'(frame_cnt), 64'd2);
        check("t2_errors", {32'(n_early), 32'(n_miss)}, 64'd0);

        // 3: junk before SOF after reset is discarded.
        do_reset();
        for (int i = 0; i < 5; i++) beat(24'h0000A0 + PW'(i), 1'b0, 1'b0, 1'b0);
        frame8(24'h000020, 0);
        drain();
        check("t3_frame_cnt", 64'(frame_cnt), 64'd1);
        check("t3_errors", {32'(n_early), 32'(n_miss)}, 64'd0);

        // 4: 30-cycle output stall while streaming three frames.
        m_if.tready = 1'b0;
        acc = 0;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            s_if.tdata  = 24'h000300 + PW'(k);
            s_if.tuser  = (k % 8 == 0);
            s_if.tlast  = !(k % 4 == 3);
            s_if.tvalid = 1'b1;
            @(negedge aclk);
            if (s_if.tready) begin
                sb_q.push_back('{d: 24'h000300 + PW'(k), u: (k % 8 == 0), l: (k % 4 == 3)});
                acc++;
                k++;
            end
            @(posedge aclk);
            #1;
        end
        s_if.tvalid = 1'b0;
        check("t4_accepted_while_stalled", 64'(acc), 64'd17);
        check("t4_s_tready_low", 64'(s_if.tready), 64'd0);
        m_if.tready = 1'b1;
        while (k < 24) begin
            beat(24'h000300 + PW'(k), (k % 8 == 0), (k % 4 == 3), 1'b1);
            k++;
        end
        drain();
        check("t4_frame_cnt", 64'(frame_cnt), 64'd4);

        // 5: early SOF truncates a frame after 5 beats.
        for (int i = 0; i < 5; i++) beat(24'h000050 + PW'(i), (i == 0), (i == 3), 1'b1);
        frame8(24'h000060, 0);
        drain();
        check("t5_early_pulses", 64'(n_early), 64'd1);
        check("t5_frame_cnt", 64'(frame_cnt), 64'd5);

        // 6: beat without SOF after a completed frame; next EOL lands three beats later.
        for (int i = 0; i < 4; i++) beat(24'h000070 + PW'(i), 1'b0, (i == 3), 1'b1);
        drain();
        check("t6_miss_pulses", 64'(n_miss), 64'd1);
        check("t6_early_pulses", 64'(n_early), 64'd1);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
